spi_slave: RTL and testbench
============================

# spi_slave

SPI mode-0 slave (CPOL=0, CPHA=0) that runs entirely in the system clock domain and oversamples the external `sck`, `mosi` and `cs` pins. Each frame is 8 bits, MSB first. Every completed received byte is stored in an echo register. That register is shifted out on `miso` during the next byte slot, so the host reads back the previous byte with one byte of delay. The block sits at the chip pin boundary as the loopback/command front end for the comm subsystem.

## Interface
Parameters:
- `WIDTH`, default 8: frame length in bits.
- `SYNC_STAGES`, default 2: flip-flop stages in each pin synchronizer (minimum 2).
- `TX_RESET`, default 8'h00: reset value of the echo register.

Ports:
- `clk`, input, 1: system clock. All state is clocked on its rising edge. Frequency must be at least 8× the `sck` frequency.
- `ar`, input, 1: reset, asynchronous and active-low.
- `sck`, input, 1: SPI clock, asynchronous to `clk`, idle low.
- `mosi`, input, 1: SPI data from the host.
- `miso`, output, 1: SPI data to the host. Always driven (no tristate).
- `cs`, input, 1: chip select, active-low, asynchronous.

## Operation
- `sck`, `mosi` and `cs` each pass through a `SYNC_STAGES`-deep synchronizer.
- A registered copy of synchronized `sck` and `cs` provides rise/fall edge detection.
- Frame start: a synchronized `cs` falling edge does the following:
  - clears the bit counter;
  - loads the tx shift register with the echo register;
  - drives `miso` with the MSB of the echo register.
- Sample: on each `sck` rising edge while `cs` is low, the synchronized `mosi` is shifted into the rx register LSB, and the bit counter increments.
- Shift: on each `sck` falling edge while `cs` is low, the tx register shifts left and `miso` takes the new MSB.
  - The falling edge that follows the 8th rising edge instead reloads tx from the freshly updated echo register.
- Byte complete (8th rising edge):
  - the echo register takes the full received byte;
  - the bit counter wraps to 0.
  - Continued clocking under the same `cs` receives the next byte. The echoed data then lags the host by one byte.
- Frame end: a `cs` rising edge before 8 bits aborts the frame:
  - partial rx bits are discarded;
  - the echo register is unchanged;
  - the counter is cleared.
- While `cs` is high, `sck` and `mosi` are ignored and `miso` is driven 0.
- Simultaneous `cs` rise and `sck` edge in the same `clk` cycle: `cs` wins and the edge is ignored.

## Timing
- Reset values:
  - `miso` = 0;
  - echo register = `TX_RESET`;
  - rx and tx shift registers = 0;
  - bit counter = 0;
  - all synchronizer and edge flops = 0, except the `cs` chain, which resets to 1 (idle).
- Latency from a pin edge to the action is `SYNC_STAGES`+1 `clk` cycles (3 at default).
- `miso` therefore changes 3 cycles after a `sck` falling edge or a `cs` falling edge.
- The host must wait at least 4 `clk` cycles between `cs` falling and the first `sck` rise, and hold each `sck` level for at least 4 `clk` cycles.
- The echo register updates 3 cycles after the 8th `sck` rise.
- Asserting `ar` mid-frame clears all state immediately. After release, the block waits for a fresh `cs` falling edge. A frame already in progress is not resumed.

## Structure
- Package `spi_pkg`: `WIDTH` default, counter width `$clog2(WIDTH)`, `TX_RESET` default.
- Sub-module `spi_sync`:
  - a `SYNC_STAGES` synchronizer plus edge detector, with outputs `level`, `rise` and `fall`;
  - reset value set by a parameter;
  - instantiated for `sck` and `cs`.
  - `mosi` uses the synchronizer only.
- Top-level `spi_slave` holds the counter, the shift registers and the echo register.

## Test plan
- `clk` period 20 ns.
- Reset: hold `ar`=0 with `cs`=1.
  - Required: `miso`=0 and echo register = 0x00.
  - Release `ar`; required: no state change.
- Frame 1: `cs` low, then send 0xC3 MSB first with `sck` 100 ns high / 100 ns low, then `cs` high.
  - Required: `miso` bits read 0x00.
  - Required: echo register = 0xC3 three cycles after the 8th rise.
- Frame 2: 200 ns idle, then send 0xA3.
  - Required: `miso` bits read 0xC3 (1,1,0,0,0,0,1,1).
  - Required: echo register = 0xA3.
- Abort: send only 5 bits of 0xFF, then `cs` high.
  - Required: echo register unchanged at 0xA3.
  - Required: the next full frame reads 0xA3 on `miso`.
- Multi-byte: one `cs` window carrying 0x5A followed by 0x3C.
  - Required: `miso` returns the prior echo value, then 0x5A.
  - Required: final echo register = 0x3C.
- Reset mid-frame: pulse `ar` low after 4 bits.
  - Required: `miso`=0, echo register = 0x00 and counter = 0.
  - Next frame of 0x81 after a new `cs` fall: required response is 0x00 on `miso` and echo register = 0x81.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared defaults for the oversampled SPI mode-0 slave.
package spi_pkg;
  localparam int                     WIDTH_DEF    = 8;
  localparam int                     CNT_W_DEF    = $clog2(WIDTH_DEF);
  localparam logic [WIDTH_DEF-1:0]   TX_RESET_DEF = 8'h00;
endpackage

// File: rtl/spi_sync.sv
// Multi-stage pin synchronizer with registered-level edge detection.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic ar,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      sync_p  <= {SYNC_STAGES{RESET_VAL}};
      level_p <= RESET_VAL;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], din};
      level_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~level_p;
  assign fall  = ~level & level_p;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully in the clk domain; echoes each received byte
// back on miso during the following byte slot.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_RESET    = TX_RESET_DEF
) (
  input  logic clk,
  input  logic ar,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  input  logic cs
);

  localparam int CW = $clog2(WIDTH);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_p;
  logic                   mosi_s;

  logic [WIDTH-1:0]   rx, tx, echo;
  logic [WIDTH-1:0]   rx_next;
  logic [CW-1:0]      bit_cnt;
  logic               active, armed;
  logic [SYNC_STAGES:0] warm;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .ar(ar), .din(sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .ar(ar), .din(cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi only needs the same latency as sck, no edge detection
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) mosi_sync_p <= '0;
    else     mosi_sync_p <= {mosi_sync_p[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s  = mosi_sync_p[SYNC_STAGES-1];
  assign rx_next = {rx[WIDTH-2:0], mosi_s};

  // warm/armed: after reset the cs chain must flush and show cs high before
  // a falling edge can open a frame, so a frame cut by reset is never resumed.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      rx      <= '0;
      tx      <= '0;
      echo    <= TX_RESET;
      bit_cnt <= '0;
      miso    <= 1'b0;
      active  <= 1'b0;
      armed   <= 1'b0;
      warm    <= '0;
    end else begin
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (cs_level) begin
        miso    <= 1'b0;
        bit_cnt <= '0;
        rx      <= '0;
        if (cs_rise)           active <= 1'b0;
        if (warm[SYNC_STAGES]) armed  <= 1'b1;
      end else if (cs_fall && armed && !sck_level) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        rx      <= '0;
        tx      <= echo;
        miso    <= echo[WIDTH-1];
      end else if (active) begin
        if (sck_rise) begin
          rx <= rx_next;
          if (bit_cnt == CW'(WIDTH-1)) begin
            echo    <= rx_next;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          // counter at zero on a fall means a byte just completed
          if (bit_cnt == '0) begin
            tx   <= echo;
            miso <= echo[WIDTH-1];
          end else begin
            tx   <= {tx[WIDTH-2:0], 1'b0};
            miso <= tx[WIDTH-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: host tasks push expected miso/echo bytes,
// a monitor collects miso bits on sck rises and checks them.
module tb_spi_slave;

  logic clk, ar, sck, mosi, miso, cs;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] e;
  } exp_t;

  exp_t       q[$];
  int         total, bad;
  logic [7:0] exp_echo;

  spi_slave dut (
    .clk(clk), .ar(ar), .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    q.push_back('{m: exp_echo, e: b});
    exp_echo = b;
    send_bits(b, 8);
  endtask

  // monitor: host-side sampling of miso, echo checked 3 clk after 8th rise
  initial begin
    int         nb;
    logic [7:0] sh;
    exp_t       e;
    nb = 0;
    sh = '0;
    forever begin
      @(posedge sck or posedge cs or negedge ar);
      if (!ar || cs) begin
        nb = 0;
      end else if (sck) begin
        sh = {sh[6:0], miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (q.size() == 0) begin
            chk("unexpected_byte", 32'(sh), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("miso_byte", 32'(sh), 32'(e.m));
            repeat (3) @(posedge clk);
            #1;
            chk("echo_after_byte", 32'(dut.echo), 32'(e.e));
          end
        end
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_echo = 8'h00;
    ar = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_echo", 32'(dut.echo), 32'h00);
    chk("reset_cnt",  32'(dut.bit_cnt), 32'h0);
    ar = 1'b1;
    repeat (6) @(negedge clk);
    chk("release_miso", 32'(miso), 32'h0);
    chk("release_echo", 32'(dut.echo), 32'h00);
    chk("release_cnt",  32'(dut.bit_cnt), 32'h0);

    // frame 1 and frame 2
    cs_low(); send_byte(8'hC3); cs_high();
    repeat (10) @(negedge clk);
    cs_low(); send_byte(8'hA3); cs_high();

    // aborted frame leaves echo untouched
    cs_low(); send_bits(8'hFF, 5); cs_high();
    chk("abort_echo", 32'(dut.echo), 32'hA3);
    chk("abort_cnt",  32'(dut.bit_cnt), 32'h0);
    chk("abort_miso", 32'(miso), 32'h0);
    cs_low(); send_byte(8'h96); cs_high();

    // two bytes under one cs window
    cs_low(); send_byte(8'h5A); send_byte(8'h3C); cs_high();
    chk("multi_echo", 32'(dut.echo), 32'h3C);

    // reset mid-frame after 4 bits
    cs_low(); send_bits(8'hF0, 4);
    @(negedge clk);
    ar = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_miso", 32'(miso), 32'h0);
    chk("midrst_echo", 32'(dut.echo), 32'h00);
    chk("midrst_cnt",  32'(dut.bit_cnt), 32'h0);
    ar = 1'b1;
    exp_echo = 8'h00;
    repeat (8) @(negedge clk);
    chk("postrst_miso", 32'(miso), 32'h0);
    cs_high();
    cs_low(); send_byte(8'h81); cs_high();
    chk("final_echo", 32'(dut.echo), 32'h81);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
